// File: rtl/tiny_cpu_pkg.sv
// Shared types and constants for the tiny CPU fetch stage.
package tiny_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] pc;
  } fetch_entry_t;

  localparam logic [7:0] DEFAULT_RESET_PC = 8'h00;

endpackage

// File: rtl/tiny_cpu_fifo.sv
// Prefetch FIFO of fetch entries; flush wins over push and pop.
module tiny_cpu_fifo
  import tiny_cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [15:0]   wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [15:0]   rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    empty   = (count == '0);
    full    = (count == DEPTH_C);
    rdata   = mem_q[rd_ptr_q[AW-1:0]];
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata;
        wr_ptr_d = wr_ptr_q + ONE_C;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + ONE_C;
      end
    end
  end

  // Storage is cleared on reset so the head outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/tiny_cpu_fetch.sv
// Instruction fetch stage: credit-limited byte fetch into a prefetch FIFO,
// with redirect flushing the buffered stream and any in-flight byte.
module tiny_cpu_fetch
  import tiny_cpu_pkg::*;
#(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_data,
  output logic [7:0] instr_pc,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(DEPTH);
  localparam logic [AW+1:0] ONE_W   = {{(AW + 1){1'b0}}, 1'b1};

  fetch_state_t  state_q, state_d;
  logic [7:0]    fetch_pc_q, fetch_pc_d;
  logic [7:0]    redir_pc_q, redir_pc_d;
  logic [AW:0]   count;
  logic          empty, full;
  logic          push, pop;
  logic [AW+1:0] occ_after_pop;
  logic          credit_now, credit_after_push;
  fetch_entry_t  push_entry, head_entry;
  logic [15:0]   head_raw;

  tiny_cpu_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head_raw),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Occupancy already discounts this cycle's pop, so credit frees up immediately.
  always_comb begin
    pop               = !empty && instr_ready;
    push              = (state_q == REQ) && mem_ack && !redirect_valid && !full;
    push_entry        = '{data: mem_data, pc: fetch_pc_q};
    occ_after_pop     = {1'b0, count} - {{(AW + 1){1'b0}}, pop};
    credit_now        = ena && (occ_after_pop < DEPTH_W);
    credit_after_push = ena && ((occ_after_pop + ONE_W) < DEPTH_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!redirect_valid && credit_now) state_d = REQ;
      end
      REQ: begin
        if (redirect_valid)  state_d = mem_ack ? IDLE : DISCARD;
        else if (mem_ack)    state_d = credit_after_push ? REQ : IDLE;
      end
      DISCARD: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = (state_q == REQ) || (state_q == DISCARD);
    mem_addr    = fetch_pc_q;
    head_entry  = head_raw;
    instr_valid = !empty;
    instr_data  = head_entry.data;
    instr_pc    = head_entry.pc;
  end

  // An unacked request keeps its address; the redirect target waits in redir_pc.
  always_comb begin
    redir_pc_d = redirect_valid ? redirect_pc : redir_pc_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid && !(mem_req && !mem_ack)) begin
      fetch_pc_d = redirect_pc;
    end else if (!redirect_valid && (state_q == REQ) && mem_ack) begin
      fetch_pc_d = fetch_pc_q + 8'd1;
    end else if ((state_q == DISCARD) && mem_ack) begin
      fetch_pc_d = redir_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      redir_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

endmodule

// File: tb/tb_tiny_cpu_fetch.sv
// Self-checking bench for tiny_cpu_fetch: directed scenarios plus random
// traffic, all compared against a queue-based reference of the fetch stream.
module tb_tiny_cpu_fetch;
  import tiny_cpu_pkg::*;

  localparam int         DEPTH    = 2;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_data;
  logic [7:0] instr_pc;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;

  tiny_cpu_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] memory [256];

  logic       ena_drv, ready_drv, redir_drv;
  logic [7:0] redir_pc_drv;
  int         lat, wait_cnt;
  bit         rand_lat;

  logic [15:0] exp_q [$];
  logic [7:0]  nxt_pc, exp_addr;
  logic        exp_req, tainted;

  int         ack_count;
  bit         pop_seen;
  logic [7:0] pop_pc;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic void resetModel();
    exp_q.delete();
    nxt_pc   = RESET_PC;
    exp_addr = RESET_PC;
    exp_req  = 1'b0;
    tainted  = 1'b0;
    wait_cnt = 0;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mem_req"},  16'(mem_req),     16'd0);
    checkOutput({tag, "_mem_addr"}, 16'(mem_addr),    16'(RESET_PC));
    checkOutput({tag, "_valid"},    16'(instr_valid), 16'd0);
    checkOutput({tag, "_data"},     16'(instr_data),  16'd0);
    checkOutput({tag, "_pc"},       16'(instr_pc),    16'd0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ack = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    resetModel();
  endtask

  // One clock: drive at negedge, check, sample, then advance the reference at posedge.
  task automatic applyStimulus();
    logic       s_ack, s_redir, s_ready, s_ena, s_req, s_valid, was_tainted, pop;
    logic [7:0] s_rpc, s_pc;
    @(negedge clk);
    ena            = ena_drv;
    instr_ready    = ready_drv;
    redirect_valid = redir_drv;
    redirect_pc    = redir_pc_drv;
    if (mem_req && (wait_cnt >= lat)) begin
      mem_ack  = 1'b1;
      mem_data = memory[mem_addr];
    end else begin
      mem_ack  = 1'b0;
      mem_data = 8'($urandom);
    end
    #1;
    checkOutput("mem_req", 16'(mem_req), 16'(exp_req));
    if (exp_req) checkOutput("mem_addr", 16'(mem_addr), 16'(exp_addr));
    checkOutput("instr_valid", 16'(instr_valid), 16'(exp_q.size() != 0));
    if (exp_q.size() != 0) checkOutput("instr_head", {instr_data, instr_pc}, exp_q[0]);
    s_ack   = mem_ack;
    s_redir = redirect_valid;
    s_rpc   = redirect_pc;
    s_ready = instr_ready;
    s_ena   = ena;
    s_req   = mem_req;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    @(posedge clk);
    if (s_req && s_ack) ack_count++;
    pop_seen = s_valid && s_ready && !s_redir;
    pop_pc   = s_pc;
    if (s_req && s_ack) begin
      wait_cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else if (s_req) begin
      wait_cnt++;
    end
    pop         = (exp_q.size() != 0) && s_ready;
    was_tainted = tainted;
    if (s_redir) begin
      exp_q.delete();
      nxt_pc  = s_rpc;
      tainted = exp_req && !s_ack;
      if (!(exp_req && !s_ack)) exp_req = 1'b0;
    end else begin
      if (pop) exp_q.delete(0);
      if (exp_req && s_ack) begin
        if (was_tainted) begin
          tainted = 1'b0;
          exp_req = 1'b0;
        end else begin
          exp_q.push_back({memory[exp_addr], exp_addr});
          nxt_pc  = exp_addr + 8'd1;
          exp_req = s_ena && (exp_q.size() < DEPTH);
          if (exp_req) exp_addr = nxt_pc;
        end
      end else if (!exp_req) begin
        exp_req = s_ena && (exp_q.size() < DEPTH);
        if (exp_req) exp_addr = nxt_pc;
      end
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         pops;
    int         n;
    bit         found;
    logic [7:0] pcs [4];
    logic [7:0] wrap_exp [4];

    for (int i = 0; i < 256; i++) memory[i] = 8'($urandom);
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    pcs      = '{8'h00, 8'h00, 8'h00, 8'h00};
    ena_drv = 1'b1; ready_drv = 1'b1; redir_drv = 1'b0; redir_pc_drv = 8'h00;
    lat = 0; rand_lat = 1'b0; ack_count = 0; pop_seen = 1'b0; pop_pc = 8'h00;
    resetModel();

    $display("[TB] reset and streaming");
    applyReset();
    checkResetValues("por");
    repeat (4) applyStimulus();
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (pop_seen) pops++;
    end
    checkOutput("stream_throughput", 16'(pops), 16'd10);

    $display("[TB] execute stalled");
    applyReset();
    ready_drv = 1'b0;
    ack_count = 0;
    repeat (8) applyStimulus();
    checkOutput("stall_acks", 16'(ack_count), 16'd2);
    checkOutput("stall_req_low", 16'(mem_req), 16'd0);
    checkOutput("stall_head_pc", 16'(instr_pc), 16'h00);
    ready_drv = 1'b1;
    applyStimulus();
    checkOutput("resume_req", 16'(mem_req), 16'd1);
    checkOutput("resume_addr", 16'(mem_addr), 16'h02);

    $display("[TB] redirect with delayed ack");
    applyReset();
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mem_req && mem_addr == 8'h05) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("reach_addr05", 16'(found), 16'd1);
    redir_drv = 1'b1; redir_pc_drv = 8'h40;
    applyStimulus();
    redir_drv = 1'b0;
    checkOutput("redir_flush_valid", 16'(instr_valid), 16'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req && mem_addr == 8'h40) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("reach_addr40", 16'(found), 16'd1);
    checkOutput("discard_empty", 16'(instr_valid), 16'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("redir_valid_seen", 16'(found), 16'd1);
    checkOutput("redir_first_pc", 16'(instr_pc), 16'h40);

    $display("[TB] redirect with ack and pop together");
    lat = 0;
    repeat (6) applyStimulus();
    checkOutput("redir_ack_setup", 16'({mem_req, instr_valid}), 16'd3);
    redir_drv = 1'b1; redir_pc_drv = 8'h80;
    applyStimulus();
    redir_drv = 1'b0;
    checkOutput("redir_ack_valid", 16'(instr_valid), 16'd0);
    applyStimulus();
    checkOutput("redir_ack_req", 16'(mem_req), 16'd1);
    checkOutput("redir_ack_addr", 16'(mem_addr), 16'h80);

    $display("[TB] pc wrap");
    redir_drv = 1'b1; redir_pc_drv = 8'hFE;
    applyStimulus();
    redir_drv = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      applyStimulus();
      if (pop_seen) begin
        pcs[n] = pop_pc;
        n++;
      end
    end
    checkOutput("wrap_count", 16'(n), 16'd4);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("wrap_pc%0d", k), 16'(pcs[k]), 16'(wrap_exp[k]));

    $display("[TB] ena dropped mid-request");
    applyReset();
    lat = 3;
    applyStimulus();
    checkOutput("ena_req_up", 16'(mem_req), 16'd1);
    ena_drv = 1'b0;
    ack_count = 0;
    for (int i = 0; i < 10 && ack_count == 0; i++) begin
      checkOutput("ena_hold_req", 16'(mem_req), 16'd1);
      checkOutput("ena_hold_addr", 16'(mem_addr), 16'(RESET_PC));
      applyStimulus();
    end
    checkOutput("ena_ack_seen", 16'(ack_count), 16'd1);
    repeat (4) begin
      applyStimulus();
      checkOutput("ena_no_req", 16'(mem_req), 16'd0);
    end

    $display("[TB] reset mid-request");
    ena_drv = 1'b1;
    lat = 5;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_req) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("rst_req_up", 16'(found), 16'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_rst");
    mem_ack = 1'b1;
    mem_data = 8'hFF;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ack = 1'b0;
    resetModel();
    checkResetValues("rst_hold");

    $display("[TB] random traffic");
    rand_lat = 1'b1;
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      ena_drv      = ($urandom_range(0, 9) != 0);
      ready_drv    = ($urandom_range(0, 9) < 7);
      redir_drv    = ($urandom_range(0, 19) == 0);
      redir_pc_drv = 8'($urandom);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
